// File: rtl/vend_pkg.sv
// Shared types, default coin values and the credit-limit helper for the vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } vend_state_e;

    typedef enum logic [1:0] {
        CR_HOLD = 2'd0,
        CR_ADD  = 2'd1,
        CR_SUB  = 2'd2,
        CR_CLR  = 2'd3
    } credit_op_e;

    localparam int DEF_PRICE      = 100;
    localparam int DEF_QUARTER    = 25;
    localparam int DEF_DOLLAR     = 100;
    localparam int DEF_MAX_CREDIT = 175;
    localparam int DEF_CREDIT_W   = 8;

    function automatic logic credit_ok(input int unsigned credit,
                                       input int unsigned value,
                                       input int unsigned max_credit);
        return (credit + value) <= max_credit;
    endfunction

endpackage

// File: rtl/vend_credit_reg.sv
// Credit register with add/subtract/clear; one-cycle update, no backpressure.
module vend_credit_reg
    import vend_pkg::*;
#(
    parameter int W = DEF_CREDIT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  credit_op_e   op_i,
    input  logic [W-1:0] amount_i,
    output logic [W-1:0] credit_o
);

    logic [W-1:0] credit_q;
    logic [W-1:0] credit_d;

    always_comb begin
        credit_d = credit_q;
        case (op_i)
            CR_ADD:  credit_d = credit_q + amount_i;
            CR_SUB:  credit_d = credit_q - amount_i;
            CR_CLR:  credit_d = '0;
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit_o = credit_q;

endmodule

// File: rtl/vending_machine_param.sv
// Vending controller: accepts quarter/dollar credit, vends at PRICE, returns change one quarter per cycle.
// All outputs registered one cycle after the sampling edge; coins arriving while busy are bounced.
module vending_machine_param
    import vend_pkg::*;
#(
    parameter int PRICE      = DEF_PRICE,
    parameter int QUARTER    = DEF_QUARTER,
    parameter int DOLLAR     = DEF_DOLLAR,
    parameter int MAX_CREDIT = DEF_MAX_CREDIT,
    parameter int CREDIT_W   = DEF_CREDIT_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                quarter,
    input  logic                dollar,
    input  logic                cancel,
    output logic                dispense,
    output logic                change,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    if (PRICE % QUARTER != 0) begin : g_chk_price
        $error("PRICE must be a multiple of QUARTER");
    end
    if (DOLLAR % QUARTER != 0) begin : g_chk_dollar
        $error("DOLLAR must be a multiple of QUARTER");
    end
    if (CREDIT_W < $clog2(MAX_CREDIT + 1)) begin : g_chk_width
        $error("CREDIT_W too narrow for MAX_CREDIT");
    end

    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(QUARTER);
    localparam logic [CREDIT_W-1:0] DOLLAR_C  = CREDIT_W'(DOLLAR);

    vend_state_e         state_q;
    vend_state_e         state_d;
    logic                dispense_q;
    logic                change_q;
    logic                coin_reject_q;
    logic                busy_q;
    logic                reject_d;
    logic                coin_vld;
    logic [CREDIT_W-1:0] coin_amt;
    logic [CREDIT_W-1:0] new_credit;
    logic [CREDIT_W-1:0] credit_q;
    credit_op_e          cr_op;
    logic [CREDIT_W-1:0] cr_amt;

    vend_credit_reg #(
        .W(CREDIT_W)
    ) u_credit (
        .clk      (clk),
        .reset_n  (reset_n),
        .op_i     (cr_op),
        .amount_i (cr_amt),
        .credit_o (credit_q)
    );

    // Dollar has priority when both coins arrive together; the quarter is bounced.
    assign coin_vld   = quarter | dollar;
    assign coin_amt   = dollar ? DOLLAR_C : (quarter ? QUARTER_C : '0);
    assign new_credit = credit_q + coin_amt;

    always_comb begin
        state_d  = state_q;
        reject_d = 1'b0;
        cr_op    = CR_HOLD;
        cr_amt   = '0;
        case (state_q)
            IDLE, COLLECT: begin
                if (coin_vld) begin
                    if (credit_ok(32'(credit_q), 32'(coin_amt), 32'(MAX_CREDIT))) begin
                        cr_op    = CR_ADD;
                        cr_amt   = coin_amt;
                        reject_d = dollar & quarter;
                        state_d  = (new_credit >= PRICE_C) ? VEND : COLLECT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (cancel && credit_q != '0) begin
                    state_d = CHANGE;
                end
            end
            VEND: begin
                reject_d = coin_vld;
                cr_op    = CR_SUB;
                cr_amt   = PRICE_C;
                state_d  = (credit_q != PRICE_C) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_d = coin_vld;
                // Clearing on the last quarter keeps a corrupted credit from wrapping.
                if (credit_q <= QUARTER_C) begin
                    cr_op   = CR_CLR;
                    state_d = IDLE;
                end else begin
                    cr_op  = CR_SUB;
                    cr_amt = QUARTER_C;
                end
            end
            default: begin
                cr_op   = CR_CLR;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            dispense_q    <= 1'b0;
            change_q      <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            dispense_q    <= (state_d == VEND);
            change_q      <= (state_d == CHANGE);
            coin_reject_q <= reject_d;
            busy_q        <= (state_d == VEND) || (state_d == CHANGE);
        end
    end

    assign dispense    = dispense_q;
    assign change      = change_q;
    assign coin_reject = coin_reject_q;
    assign busy        = busy_q;
    assign credit      = credit_q;

endmodule
